sw_conditioner: RTL
===================

SW_CONDITIONER -- requirements
Module: sw_conditioner

Interface
REQ-001 The block SHALL have parameter N_SW, default 2, giving the number of independent switch channels (1..8).
REQ-002 The block SHALL have parameter DEBOUNCE_CYC, default 16, giving the CLK cycles a new level must persist before it is accepted (2..65535).
REQ-003 The block SHALL use one clock, CLK, and an asynchronous active-low reset, NRST.
REQ-004 Port CLK: input, 1 bit, system clock, 50 MHz, all logic on its rising edge.
REQ-005 Port NRST: input, 1 bit, asynchronous active-low reset.
REQ-006 Port sw_raw: input, N_SW bits, raw asynchronous switch levels, one bit per channel.
REQ-007 Port sw_level: output, N_SW bits, debounced switch level.
REQ-008 Port sw_rise: output, N_SW bits, one-cycle pulse when sw_level goes 0 to 1.
REQ-009 Port sw_fall: output, N_SW bits, one-cycle pulse when sw_level goes 1 to 0.
REQ-010 Port sw_toggle: output, N_SW bits, level that flips on each debounced rise (see Configuration).

Function
REQ-011 Each sw_raw bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each channel SHALL run its own 4-state FSM: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
REQ-013 In STABLE_LO, a synchronized 1 SHALL move the FSM to CHK_HI and load the channel counter with 1.
REQ-014 In CHK_HI, a synchronized 1 SHALL increment the counter, and the FSM SHALL enter STABLE_HI when the counter reaches DEBOUNCE_CYC.
REQ-015 In CHK_HI, a synchronized 0 SHALL return the FSM to STABLE_LO and clear the counter, with no output change.
REQ-016 STABLE_HI and CHK_LO SHALL behave symmetrically to REQ-013 to REQ-015 with levels inverted.
REQ-017 Each counter SHALL be $clog2(DEBOUNCE_CYC+1) bits wide, SHALL saturate and never wrap, and SHALL be cleared on every return to a STABLE state.
REQ-018 sw_level SHALL be 1 exactly when the FSM is in STABLE_HI or CHK_LO, and SHALL be registered.
REQ-019 Latency from the first CLK edge that samples a new raw level to the sw_level update SHALL be DEBOUNCE_CYC+2 cycles.
REQ-020 sw_rise and sw_fall SHALL assert in the same cycle that sw_level changes, and SHALL last exactly one cycle.
REQ-021 A raw pulse or glitch shorter than DEBOUNCE_CYC cycles SHALL produce no change on any output.
REQ-022 Channels SHALL be fully independent, so simultaneous events on several channels produce simultaneous pulses.
REQ-023 sw_rise and sw_fall SHALL never both be 1 on the same channel.

Reset
REQ-024 NRST low SHALL immediately clear the synchronizers, counters, sw_level, sw_rise, sw_fall and sw_toggle to 0, and put every FSM in STABLE_LO.
REQ-025 Reset asserted during CHK_HI or CHK_LO SHALL abort the check with no pulse generated.
REQ-026 A switch held at 1 through reset release SHALL be treated as a new rising level, producing one sw_rise after DEBOUNCE_CYC+2 cycles.

Configuration
REQ-027 When macro SW_TOGGLE_EN is defined, sw_toggle[i] SHALL invert on every sw_rise[i] in the same clock edge, and SHALL reset to 0.
REQ-028 When SW_TOGGLE_EN is undefined, sw_toggle SHALL be constant 0 and no toggle flops SHALL be synthesized.

Verification
REQ-029 Scenario, clean rise: with DEBOUNCE_CYC=16, set sw_raw[0]=1 at a negedge -> sw_level[0]=1 and one sw_rise[0] pulse 18 cycles later; sw_level[1] stays 0.
REQ-030 Scenario, glitch: sw_raw[0] high for 10 cycles then low -> sw_level, sw_rise and sw_fall stay 0 throughout.
REQ-031 Scenario, bounce: toggle sw_raw[1] every 3 cycles for 30 cycles, then hold at 1 -> exactly one sw_rise[1], 18 cycles after the final edge.
REQ-032 Scenario, simultaneous channels: set sw_raw to 2'b11 at one edge, then to 2'b00 40 cycles later -> both rise pulses in the same cycle, then both fall pulses in the same cycle.
REQ-033 Scenario, reset mid-check: assert NRST at cycle 8 of CHK_HI -> all outputs 0 at once; switch still at 1 after release gives sw_rise 18 cycles later.
REQ-034 Scenario, toggle (SW_TOGGLE_EN defined): three debounced presses of sw_raw[0] -> sw_toggle[0] goes 1, 0, 1; with the macro undefined, sw_toggle stays 0.

Source files
------------

// File: rtl/sw_conditioner.sv
// sw_conditioner: per-channel switch debouncer producing a clean level, rise/fall pulses and a toggle.
// Optional macro SW_TOGGLE_EN builds the sw_toggle flops; when undefined sw_toggle is tied to 0.
module sw_conditioner #(
  parameter int N_SW         = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic            CLK,
  input  logic            NRST,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic [N_SW-1:0] sw_toggle
);

  localparam int              CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]   DEB     = CW'(DEBOUNCE_CYC);
  localparam logic [CW-1:0]   CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } state_t;

  logic [N_SW-1:0] r_sync1;
  logic [N_SW-1:0] r_sync2;
  logic [N_SW-1:0] r_level;
  logic [N_SW-1:0] r_rise;
  logic [N_SW-1:0] r_fall;
  logic [N_SW-1:0] w_level_next;
  logic [N_SW-1:0] w_rise_next;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= sw_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_ch
      state_t          r_state;
      state_t          w_state_next;
      logic [CW-1:0]   r_cnt;
      logic [CW-1:0]   w_cnt_next;
      logic [CW-1:0]   w_cnt_inc;

      assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

      always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
          r_state <= STABLE_LO;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
          STABLE_LO: begin
            if (r_sync2[gi]) begin
              w_state_next = CHK_HI;
              w_cnt_next   = CW'(1);
            end
          end
          CHK_HI: begin
            if (!r_sync2[gi]) begin
              w_state_next = STABLE_LO;
              w_cnt_next   = '0;
            end else if (w_cnt_inc >= DEB) begin
              w_state_next = STABLE_HI;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next   = w_cnt_inc;
            end
          end
          STABLE_HI: begin
            if (!r_sync2[gi]) begin
              w_state_next = CHK_LO;
              w_cnt_next   = CW'(1);
            end
          end
          CHK_LO: begin
            if (r_sync2[gi]) begin
              w_state_next = STABLE_HI;
              w_cnt_next   = '0;
            end else if (w_cnt_inc >= DEB) begin
              w_state_next = STABLE_LO;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next   = w_cnt_inc;
            end
          end
          default: begin
            w_state_next = STABLE_LO;
            w_cnt_next   = '0;
          end
        endcase
      end

      // Level is decoded from the current state and registered once more below.
      assign w_level_next[gi] = (r_state == STABLE_HI) || (r_state == CHK_LO);
    end
  endgenerate

  assign w_rise_next = w_level_next & ~r_level;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_level <= '0;
      r_rise  <= '0;
      r_fall  <= '0;
    end else begin
      r_level <= w_level_next;
      r_rise  <= w_rise_next;
      r_fall  <= ~w_level_next & r_level;
    end
  end

  assign sw_level = r_level;
  assign sw_rise  = r_rise;
  assign sw_fall  = r_fall;

`ifdef SW_TOGGLE_EN
  logic [N_SW-1:0] r_toggle;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_toggle <= '0;
    end else begin
      r_toggle <= r_toggle ^ w_rise_next;
    end
  end

  assign sw_toggle = r_toggle;
`else
  assign sw_toggle = '0;
`endif

endmodule
